// File: rtl/pkt_tx_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module : pkt_tx_gen_pkg
// Brief  : Shared types, length limits and data-word formatting for pkt_tx_gen
// Rev    : 1.0  initial release
// ============================================================================
package pkt_tx_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;

  function automatic logic [63:0] fmt_word(input logic [31:0] seq, input logic [15:0] idx);
    return {seq, 16'h0000, idx};
  endfunction

  // 1518 needs 11 bits regardless of how wide the length port is configured
  function automatic logic [10:0] clamp_len(input logic [31:0] len);
    if (len < 32'(MIN_LEN))
      return 11'(MIN_LEN);
    else if (len > 32'(MAX_LEN))
      return 11'(MAX_LEN);
    else
      return 11'(len);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_tx_gen.sv
`default_nettype none
// ============================================================================
// Module : pkt_tx_gen
// Brief  : Burst packet generator for a 64-bit MAC TX FIFO interface.
//          Define PKT_TX_GEN_IPG_EN to add a programmable inter-packet gap.
// Rev    : 1.0  initial release
// ============================================================================
module pkt_tx_gen
  import pkt_tx_gen_pkg::*;
#(
  parameter int SEQ_W = 32,
  parameter int LEN_W = 11
) (
  input  logic             clk_156m25,
  input  logic             reset_156m25_n,
  input  logic             start,
  input  logic             stop,
  input  logic [LEN_W-1:0] pkt_len,
  input  logic [15:0]      pkt_count,
`ifdef PKT_TX_GEN_IPG_EN
  input  logic [7:0]       ipg_cycles,
`endif
  input  logic             pkt_tx_full,
  output logic [63:0]      pkt_tx_data,
  output logic             pkt_tx_val,
  output logic             pkt_tx_sop,
  output logic             pkt_tx_eop,
  output logic [2:0]       pkt_tx_mod,
  output logic             busy,
  output logic             done,
  output logic [SEQ_W-1:0] pkts_sent
);

  state_t      r_state;
  logic [2:0]  r_mod;
  logic [7:0]  r_last_idx;
  logic [7:0]  r_word_idx;
  logic [15:0] r_count;
  logic [15:0] r_burst_cnt;
  logic        r_stop_pend;
  logic [7:0]  r_gap_cnt;

  logic [31:0] w_seq32;
  logic [10:0] w_len_in;
  logic [7:0]  w_last_in;
  logic [15:0] w_burst_next;
  logic        w_count_hit;
  logic        w_stop_any;
  logic        w_is_eop;
  logic [7:0]  w_ipg;

`ifdef PKT_TX_GEN_IPG_EN
  logic [7:0] r_ipg;
  assign w_ipg = r_ipg;
`else
  assign w_ipg = 8'd0;
`endif

  generate
    if (SEQ_W >= 32) begin : g_seq_trunc
      assign w_seq32 = pkts_sent[31:0];
    end else begin : g_seq_ext
      assign w_seq32 = {{(32-SEQ_W){1'b0}}, pkts_sent};
    end
  endgenerate

  // Last word index = ceil(len/8) - 1, without a wide adder
  assign w_len_in     = clamp_len(32'(pkt_len));
  assign w_last_in    = w_len_in[10:3] - {7'd0, (w_len_in[2:0] == 3'd0)};
  assign w_burst_next = r_burst_cnt + 16'd1;
  assign w_count_hit  = (r_count != 16'd0) && (w_burst_next == r_count);
  assign w_stop_any   = r_stop_pend | stop;
  assign w_is_eop     = (r_word_idx == r_last_idx);

  always_ff @(posedge clk_156m25) begin
    if (!reset_156m25_n) begin
      r_state     <= ST_IDLE;
      r_mod       <= 3'd0;
      r_last_idx  <= 8'd0;
      r_word_idx  <= 8'd0;
      r_count     <= 16'd0;
      r_burst_cnt <= 16'd0;
      r_stop_pend <= 1'b0;
      r_gap_cnt   <= 8'd0;
`ifdef PKT_TX_GEN_IPG_EN
      r_ipg       <= 8'd0;
`endif
      pkt_tx_data <= 64'd0;
      pkt_tx_val  <= 1'b0;
      pkt_tx_sop  <= 1'b0;
      pkt_tx_eop  <= 1'b0;
      pkt_tx_mod  <= 3'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pkts_sent   <= '0;
    end else begin
      pkt_tx_val <= 1'b0;
      pkt_tx_sop <= 1'b0;
      pkt_tx_eop <= 1'b0;
      pkt_tx_mod <= 3'd0;
      done       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_stop_pend <= 1'b0;
          if (start) begin
            r_state     <= ST_SEND;
            busy        <= 1'b1;
            r_mod       <= w_len_in[2:0];
            r_last_idx  <= w_last_in;
            r_count     <= pkt_count;
            r_burst_cnt <= 16'd0;
            r_word_idx  <= 8'd0;
`ifdef PKT_TX_GEN_IPG_EN
            r_ipg       <= ipg_cycles;
`endif
          end
        end
        ST_SEND: begin
          if (stop) r_stop_pend <= 1'b1;
          // Under backpressure the index and data word simply hold
          if (!pkt_tx_full) begin
            pkt_tx_val  <= 1'b1;
            pkt_tx_sop  <= (r_word_idx == 8'd0);
            pkt_tx_eop  <= w_is_eop;
            pkt_tx_data <= fmt_word(w_seq32, {8'h00, r_word_idx});
            if (w_is_eop) begin
              pkt_tx_mod  <= r_mod;
              pkts_sent   <= pkts_sent + SEQ_W'(1);
              r_burst_cnt <= w_burst_next;
              r_word_idx  <= 8'd0;
              if (w_stop_any || w_count_hit) begin
                r_state     <= ST_IDLE;
                busy        <= 1'b0;
                done        <= 1'b1;
                r_stop_pend <= 1'b0;
              end else if (w_ipg != 8'd0) begin
                r_state   <= ST_GAP;
                r_gap_cnt <= w_ipg;
              end
            end else begin
              r_word_idx <= r_word_idx + 8'd1;
            end
          end
        end
        ST_GAP: begin
          if (stop) r_stop_pend <= 1'b1;
          r_gap_cnt <= r_gap_cnt - 8'd1;
          if (r_gap_cnt == 8'd1) begin
            if (w_stop_any) begin
              r_state     <= ST_IDLE;
              busy        <= 1'b0;
              done        <= 1'b1;
              r_stop_pend <= 1'b0;
            end else begin
              r_state <= ST_SEND;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pkt_tx_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_pkt_tx_gen
// Brief  : Directed and randomized bench for pkt_tx_gen with a word-list model
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pkt_tx_gen;

  logic        clk_156m25 = 1'b0;
  logic        reset_156m25_n;
  logic        start;
  logic        stop;
  logic [10:0] pkt_len;
  logic [15:0] pkt_count;
  logic        pkt_tx_full;
`ifdef PKT_TX_GEN_IPG_EN
  logic [7:0]  ipg_cycles;
`endif
  logic [63:0] pkt_tx_data;
  logic        pkt_tx_val;
  logic        pkt_tx_sop;
  logic        pkt_tx_eop;
  logic [2:0]  pkt_tx_mod;
  logic        busy;
  logic        done;
  logic [31:0] pkts_sent;

  int n_vec = 0;
  int n_err = 0;
  int exp_n = 0;

  always #3 clk_156m25 = ~clk_156m25;

  pkt_tx_gen #(.SEQ_W(32), .LEN_W(11)) dut (
    .clk_156m25     (clk_156m25),
    .reset_156m25_n (reset_156m25_n),
    .start          (start),
    .stop           (stop),
    .pkt_len        (pkt_len),
    .pkt_count      (pkt_count),
`ifdef PKT_TX_GEN_IPG_EN
    .ipg_cycles     (ipg_cycles),
`endif
    .pkt_tx_full    (pkt_tx_full),
    .pkt_tx_data    (pkt_tx_data),
    .pkt_tx_val     (pkt_tx_val),
    .pkt_tx_sop     (pkt_tx_sop),
    .pkt_tx_eop     (pkt_tx_eop),
    .pkt_tx_mod     (pkt_tx_mod),
    .busy           (busy),
    .done           (done),
    .pkts_sent      (pkts_sent)
  );

  task automatic tick();
    @(posedge clk_156m25);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Expected word k of the current packet, from the length rules alone
  task automatic check_word(input int k, input int w, input int l);
    logic [63:0] ew;
    ew = {32'(exp_n), 16'h0000, 16'(k)};
    chk("data", pkt_tx_data, ew);
    chk("sop", 64'(pkt_tx_sop), 64'(k == 0));
    chk("eop", 64'(pkt_tx_eop), 64'(k == w - 1));
    chk("mod", 64'(pkt_tx_mod), 64'((k == w - 1) ? (l % 8) : 0));
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_val"},  64'(pkt_tx_val), 64'd0);
    chk({tag, "_sop"},  64'(pkt_tx_sop), 64'd0);
    chk({tag, "_eop"},  64'(pkt_tx_eop), 64'd0);
    chk({tag, "_mod"},  64'(pkt_tx_mod), 64'd0);
    chk({tag, "_data"}, pkt_tx_data, 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_sent"}, 64'(pkts_sent), 64'd0);
  endtask

  // fmode: 0 no backpressure, 1 random backpressure and stray starts,
  //        2 full held for 5 cycles when word 3 of the first packet is due
  task automatic run_burst(input int len, input int cnt, input int stop_pkt,
                           input int fmode, input int exp_lows, input bit stop_with_start);
    int l, w, npk, k, p, cyc, lows, fcnt;
    bit fused, stop_sent, started, fin, drv_full, extra_val, extra_done;
    logic [63:0] last_data;
    l   = (len < 64) ? 64 : ((len > 1518) ? 1518 : len);
    w   = (l + 7) / 8;
    npk = (stop_pkt >= 0) ? stop_pkt + 1 : cnt;
    k = 0; p = 0; cyc = 0; lows = 0; fcnt = 0;
    fused = 0; stop_sent = 0; started = 0; fin = 0;
    last_data = '0;
    start = 1'b1; stop = stop_with_start;
    pkt_len = 11'(len); pkt_count = 16'(cnt); pkt_tx_full = 1'b0;
    tick();
    start = 1'b0; stop = 1'b0;
    pkt_len = 11'($urandom); pkt_count = 16'($urandom_range(1, 9));
    chk("busy_after_start", 64'(busy), 64'd1);
    while (!fin && cyc < 8000) begin
      if (fmode == 2 && !fused && p == 0 && k == 3) begin
        fcnt = 5; fused = 1;
      end
      drv_full = (fmode == 1) ? ($urandom_range(0, 3) == 0) : (fcnt > 0);
      if (fcnt > 0) fcnt--;
      pkt_tx_full = drv_full;
      stop = (stop_pkt >= 0 && !stop_sent && p == stop_pkt && k == 4);
      if (stop) stop_sent = 1;
      start = (fmode == 1) && ($urandom_range(0, 15) == 0);
      tick();
      cyc++;
      if (drv_full) chk("val_while_full", 64'(pkt_tx_val), 64'd0);
      if (pkt_tx_val) begin
        check_word(k, w, l);
        last_data = pkt_tx_data;
        started = 1;
        if (k == w - 1) begin
          k = 0; p++; exp_n++;
        end else begin
          k++;
        end
      end else if (started && !done) begin
        lows++;
        if (fmode == 2) chk("hold_data", pkt_tx_data, last_data);
      end
      if (done) begin
        fin = 1;
        chk("burst_pkts", 64'(p), 64'(npk));
      end
    end
    chk("burst_finished", 64'(fin), 64'd1);
    if (exp_lows >= 0) chk("val_low_cycles", 64'(lows), 64'(exp_lows));
    start = 1'b0; stop = 1'b0; pkt_tx_full = 1'b0;
    extra_val = 0; extra_done = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      extra_val  |= pkt_tx_val;
      extra_done |= done;
    end
    chk("idle_no_val", 64'(extra_val), 64'd0);
    chk("single_done", 64'(extra_done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("pkts_sent", 64'(pkts_sent), 64'(exp_n));
  endtask

  initial begin
    int k, cyc;
    bit any_val;
    reset_156m25_n = 1'b0;
    start = 1'b0; stop = 1'b0; pkt_len = 11'd64; pkt_count = 16'd1; pkt_tx_full = 1'b0;
`ifdef PKT_TX_GEN_IPG_EN
    ipg_cycles = 8'd0;
`endif
    repeat (3) tick();
    check_idle_outputs("reset");
    reset_156m25_n = 1'b1;
    tick();

    run_burst(64, 1, -1, 0, 0, 1'b0);
    run_burst(69, 1, -1, 0, 0, 1'b0);
    run_burst(10, 1, -1, 0, 0, 1'b0);
    run_burst(2000, 1, -1, 0, 0, 1'b0);
    run_burst(200, 1, -1, 2, 5, 1'b0);

    // stop seen in IDLE must not leak into the next burst
    stop = 1'b1; tick(); stop = 1'b0; tick();
    run_burst(64, 2, -1, 0, 0, 1'b0);
    run_burst(72, 2, -1, 0, 0, 1'b1);
    run_burst(100, 0, 2, 0, 0, 1'b0);

    for (int i = 0; i < 6; i++)
      run_burst(int'($urandom_range(1, 1700)), int'($urandom_range(1, 3)), -1, 1, -1, 1'b0);

`ifdef PKT_TX_GEN_IPG_EN
    ipg_cycles = 8'd12;
    run_burst(64, 2, -1, 0, 12, 1'b0);
    ipg_cycles = 8'd0;
`endif

    // Reset while word 4 of a packet is due
    start = 1'b1; pkt_len = 11'd64; pkt_count = 16'd1;
    tick();
    start = 1'b0;
    k = 0; cyc = 0;
    while (k < 4 && cyc < 50) begin
      tick(); cyc++;
      if (pkt_tx_val) begin
        check_word(k, 8, 64);
        k++;
      end
    end
    chk("mid_words_seen", 64'(k), 64'd4);
    reset_156m25_n = 1'b0;
    tick();
    check_idle_outputs("mid_reset");
    exp_n = 0;
    reset_156m25_n = 1'b1;
    any_val = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      any_val |= pkt_tx_val;
    end
    chk("no_resume", 64'(any_val), 64'd0);
    run_burst(64, 1, -1, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pkt_tx_gen.md
PKT_TX_GEN -- requirements
Module: pkt_tx_gen

Interface
REQ-001 SHALL have parameter SEQ_W, default 32, width of the packet sequence counter and pkts_sent.
REQ-002 SHALL have parameter LEN_W, default 11, width of pkt_len.
REQ-003 clk_156m25  in  1  sole clock; all logic on its rising edge.
REQ-004 reset_156m25_n  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  pulse; begins a burst when idle.
REQ-006 stop  in  1  pulse; ends the burst at the next packet boundary.
REQ-007 pkt_len  in  LEN_W  packet length in bytes, sampled on accepted start.
REQ-008 pkt_count  in  16  packets per burst, sampled on accepted start; 0 = continuous.
REQ-009 pkt_tx_full  in  1  MAC TX FIFO full (backpressure).
REQ-010 pkt_tx_data  out  64  MAC TX data word.
REQ-011 pkt_tx_val / pkt_tx_sop / pkt_tx_eop  out  1 each  word valid / first word / last word.
REQ-012 pkt_tx_mod  out  3  valid bytes in the eop word; 0 = all 8.
REQ-013 busy  out  1  burst in progress; done  out  1  one-cycle pulse at burst end; pkts_sent  out  SEQ_W  packets completed since reset.

Function
REQ-014 SHALL implement FSM states IDLE, SEND, GAP.
REQ-015 IDLE->SEND on start; start is ignored outside IDLE.
REQ-016 On accepted start, SHALL latch pkt_len clamped to [64,1518] and pkt_count, and clear the burst counter and word index.
REQ-017 Word count SHALL be ceil(len/8); pkt_tx_mod on eop SHALL be len[2:0]; mod SHALL be 0 on non-eop words.
REQ-018 Word k of packet n SHALL be {n[31:0], 16'h0, k[15:0]}, where n = pkts_sent truncated/zero-extended to 32 bits.
REQ-019 All outputs SHALL be registered; pkt_tx_val asserts in cycle t+1 only if pkt_tx_full was 0 in cycle t.
REQ-020 While pkt_tx_full=1, SHALL deassert val, sop, eop, and hold the word index and data; resume with the same word when full drops.
REQ-021 sop and eop SHALL be asserted only together with val; a 1-word packet is impossible given the 64-byte minimum.
REQ-022 On the eop word, SHALL increment pkts_sent (wrapping at 2^SEQ_W) and the burst counter.
REQ-023 After eop: if a stop is pending or burst counter equals nonzero pkt_count, go to IDLE with done=1 for one cycle; otherwise go to GAP (REQ-031) or directly to SEND with the sop of the next packet in the following cycle.
REQ-024 stop SHALL be latched and never truncate a packet; stop in IDLE is ignored and cleared.
REQ-025 start and stop in the same IDLE cycle: start is accepted and stop discarded.
REQ-026 busy SHALL be 1 in SEND and GAP, and 0 in IDLE.

Reset
REQ-027 With reset_156m25_n=0 at a clock edge, SHALL enter IDLE and zero every output, pkts_sent, and all internal counters and flags on that edge, including mid-packet.
REQ-028 A packet cut by reset SHALL NOT be resumed; the MAC sees no eop for it.

Configuration
REQ-029 Macro PKT_TX_GEN_IPG_EN SHALL enable the inter-packet gap feature.
REQ-030 With PKT_TX_GEN_IPG_EN defined: add input ipg_cycles [7:0], sampled on start.
REQ-031 With PKT_TX_GEN_IPG_EN defined: after a non-final eop, stay in GAP with val=0 for ipg_cycles cycles (0 = skip GAP).
REQ-032 With PKT_TX_GEN_IPG_EN defined: a stop pending during GAP ends the burst at the end of the gap.
REQ-033 Without PKT_TX_GEN_IPG_EN: no ipg_cycles port, GAP state unreachable, packets back-to-back.

Structure
REQ-034 Package pkt_tx_gen_pkg SHALL hold the state enum, MIN_LEN=64, MAX_LEN=1518, and the data-word format function.
REQ-035 Single module; no sub-module.

Verification
REQ-036 Length and format: len=64, count=1, full=0 -> 8 words, sop on word 0, eop on word 7, mod=0, data {0,16'h0,k}, done pulse, pkts_sent=1.
REQ-037 Partial last word and clamping: len=69 -> 9 words, eop mod=5; len=10 -> clamped to 64; len=2000 -> clamped to 1518, 190 words, mod=6.
REQ-038 Backpressure: full=1 for 5 cycles at word 3 -> val low for 5 cycles, word 3 repeated unchanged afterward, no word lost or duplicated.
REQ-039 Stop and continuous mode: count=0, stop mid-packet 2 -> packet 2 completes with eop, then IDLE and done; pkts_sent=3.
REQ-040 Reset mid-packet: reset at word 4 -> all outputs 0 next edge, IDLE, pkts_sent=0; a later start sends from sop.
REQ-041 IPG (PKT_TX_GEN_IPG_EN): ipg_cycles=12, count=2 -> exactly 12 val-low cycles between eop and the next sop.
